// File: rtl/pgs_pkg.sv
// Shared types and sizing helpers for the power gate sequencer.
package pgs_pkg;

    typedef enum logic [2:0] {
        PGS_OFF     = 3'd0,
        PGS_WAKE    = 3'd1,
        PGS_SETTLE  = 3'd2,
        PGS_RELEASE = 3'd3,
        PGS_ON      = 3'd4,
        PGS_ISOLATE = 3'd5
    } pgs_state_t;

    function automatic int pgs_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pgs_dly_timer.sv
// Loadable down-counter; done_o is high during the last cycle of a loaded delay.
module pgs_dly_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the register only, so the FSM may reload in the same cycle without a loop.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/power_gate_sequencer.sv
// Stages PMOS header segments on one at a time, then releases isolation and domain reset;
// powers down by clamping first and opening all headers after a settle delay.
module power_gate_sequencer
    import pgs_pkg::*;
#(
    parameter int N_STAGES  = 4,
    parameter int STAGE_DLY = 3,
    parameter int ISO_DLY   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwr_req,
    output logic                pwr_ack,
    output logic [N_STAGES-1:0] sw_en_n,
    output logic                iso_n,
    output logic                dom_rst_n,
    output logic                busy
);

    localparam int CW = $clog2(pgs_max(STAGE_DLY, ISO_DLY) + 1);
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CW-1:0] STAGE_LD   = CW'(STAGE_DLY);
    localparam logic [CW-1:0] ISO_LD     = CW'(ISO_DLY);
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

    pgs_state_t          state_q, state_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [N_STAGES-1:0] sw_en_n_q, sw_en_n_d;
    logic                iso_n_q, iso_n_d;
    logic                dom_rst_n_q, dom_rst_n_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                tmr_load;
    logic [CW-1:0]       tmr_val;
    logic                tmr_done;

    logic [SW-1:0]       stage_nxt;
    logic [N_STAGES-1:0] stage_sel;

    assign stage_nxt = stage_q + SW'(1);

    // One-hot mask of the segment that turns on next.
    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_sel
            assign stage_sel[gi] = (stage_nxt == SW'(gi));
        end
    endgenerate

    pgs_dly_timer #(
        .W (CW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        sw_en_n_d   = sw_en_n_q;
        iso_n_d     = iso_n_q;
        dom_rst_n_d = dom_rst_n_q;
        ack_d       = ack_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            PGS_OFF: begin
                if (pwr_req) begin
                    stage_d      = '0;
                    sw_en_n_d    = '1;
                    sw_en_n_d[0] = 1'b0;
                    tmr_load     = 1'b1;
                    // A single segment is fully on at once, so go straight to the settle wait.
                    if (N_STAGES == 1) begin
                        state_d = PGS_SETTLE;
                        tmr_val = ISO_LD;
                    end else begin
                        state_d = PGS_WAKE;
                        tmr_val = STAGE_LD;
                    end
                end
            end
            PGS_WAKE: begin
                if (tmr_done) begin
                    stage_d   = stage_nxt;
                    sw_en_n_d = sw_en_n_q & ~stage_sel;
                    tmr_load  = 1'b1;
                    if (stage_nxt == LAST_STAGE) begin
                        state_d = PGS_SETTLE;
                        tmr_val = ISO_LD;
                    end else begin
                        tmr_val = STAGE_LD;
                    end
                end
            end
            PGS_SETTLE: begin
                if (tmr_done) begin
                    state_d = PGS_RELEASE;
                    iso_n_d = 1'b1;
                end
            end
            PGS_RELEASE: begin
                state_d     = PGS_ON;
                dom_rst_n_d = 1'b1;
                ack_d       = 1'b1;
            end
            PGS_ON: begin
                if (!pwr_req) begin
                    state_d     = PGS_ISOLATE;
                    iso_n_d     = 1'b0;
                    dom_rst_n_d = 1'b0;
                    ack_d       = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = ISO_LD;
                end
            end
            PGS_ISOLATE: begin
                if (tmr_done) begin
                    state_d   = PGS_OFF;
                    sw_en_n_d = '1;
                end
            end
            default: begin
                state_d = PGS_OFF;
            end
        endcase

        busy_d = (state_d == PGS_WAKE) || (state_d == PGS_SETTLE) ||
                 (state_d == PGS_RELEASE) || (state_d == PGS_ISOLATE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PGS_OFF;
            stage_q     <= '0;
            sw_en_n_q   <= '1;
            iso_n_q     <= 1'b0;
            dom_rst_n_q <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            sw_en_n_q   <= sw_en_n_d;
            iso_n_q     <= iso_n_d;
            dom_rst_n_q <= dom_rst_n_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign sw_en_n   = sw_en_n_q;
    assign iso_n     = iso_n_q;
    assign dom_rst_n = dom_rst_n_q;
    assign pwr_ack   = ack_q;
    assign busy      = busy_q;

endmodule
